amt: RTL and testbench

//  Architectural Map Table. Retire-side counterpart of the speculative map table (MT).

---
 rtl/amt_pkg.sv | 28 ++
 rtl/amt_rt_chain.sv | 38 +++
 rtl/amt.sv | 77 +++++++
 tb/tb_amt.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/amt_pkg.sv
// Shared types and sizing for the architectural map table.
`default_nettype none

package amt_pkg;

  localparam int RT_NUM         = 2;
  localparam int MT_ENTRY_NUM   = 32;
  localparam int TAG_IDX_WIDTH  = 6;
  localparam int ARCH_IDX_WIDTH = $clog2(MT_ENTRY_NUM);

  typedef struct packed {
    logic                      valid;
    logic [ARCH_IDX_WIDTH-1:0] arch_reg;
    logic [TAG_IDX_WIDTH-1:0]  tag;
  } rob_amt_t;

  typedef struct packed {
    logic [TAG_IDX_WIDTH-1:0] amt_tag;
  } amt_entry_t;

  typedef struct packed {
    logic                     valid;
    logic [TAG_IDX_WIDTH-1:0] tag;
  } amt_fl_t;

endpackage

`default_nettype wire

// File: rtl/amt_rt_chain.sv
// Ordered intra-cycle retire forwarding: each channel sees the mappings
// already updated by older channels of the same cycle.
`default_nettype none

module amt_rt_chain
  import amt_pkg::*;
#(
  parameter int C_RT_NUM       = RT_NUM,
  parameter int C_MT_ENTRY_NUM = MT_ENTRY_NUM
) (
  input  amt_entry_t [C_MT_ENTRY_NUM-1:0] cur_entries,
  input  rob_amt_t   [C_RT_NUM-1:0]       retire,
  output logic       [C_RT_NUM-1:0][TAG_IDX_WIDTH-1:0] old_tags,
  output amt_entry_t [C_MT_ENTRY_NUM-1:0] next_entries
);

  amt_entry_t [C_MT_ENTRY_NUM-1:0] work;

  always_comb begin
    work     = cur_entries;
    old_tags = '0;
    for (int k = 0; k < C_RT_NUM; k++) begin
      if (retire[k].valid) begin
        // x0 is hardwired: its retiring tag goes straight back to the free list
        if (retire[k].arch_reg == '0) begin
          old_tags[k] = retire[k].tag;
        end else begin
          old_tags[k]                       = work[retire[k].arch_reg].amt_tag;
          work[retire[k].arch_reg].amt_tag  = retire[k].tag;
        end
      end
    end
    next_entries = work;
  end

endmodule

`default_nettype wire

// File: rtl/amt.sv
// Architectural map table: committed arch->phys mapping, freed-tag output
// registered one cycle after retirement.
`default_nettype none

module amt
  import amt_pkg::*;
#(
  parameter int C_RT_NUM        = RT_NUM,
  parameter int C_MT_ENTRY_NUM  = MT_ENTRY_NUM,
  parameter int C_TAG_IDX_WIDTH = TAG_IDX_WIDTH
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic                            rollback_i,
  input  rob_amt_t   [C_RT_NUM-1:0]       rob_amt_i,
  output amt_entry_t [C_MT_ENTRY_NUM-1:0] amt_o,
  output amt_fl_t    [C_RT_NUM-1:0]       amt_fl_o
);

  amt_entry_t [C_MT_ENTRY_NUM-1:0]                entries;
  amt_entry_t [C_MT_ENTRY_NUM-1:0]                next_entries;
  amt_fl_t    [C_RT_NUM-1:0]                      fl_regs;
  logic       [C_RT_NUM-1:0][TAG_IDX_WIDTH-1:0]   old_tags;
  logic       [C_RT_NUM-1:0]                      rt_valid;

  amt_rt_chain #(
    .C_RT_NUM       (C_RT_NUM),
    .C_MT_ENTRY_NUM (C_MT_ENTRY_NUM)
  ) u_chain (
    .cur_entries  (entries),
    .retire       (rob_amt_i),
    .old_tags     (old_tags),
    .next_entries (next_entries)
  );

  always_comb begin
    rt_valid = '0;
    for (int k = 0; k < C_RT_NUM; k++) begin
      rt_valid[k] = rob_amt_i[k].valid;
    end
  end

  // Identity reset keeps this table in agreement with the speculative map.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < C_MT_ENTRY_NUM; i++) begin
        entries[i].amt_tag <= C_TAG_IDX_WIDTH'(i);
      end
    end else begin
      entries <= next_entries;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fl_regs <= '0;
    end else begin
      for (int k = 0; k < C_RT_NUM; k++) begin
        fl_regs[k].valid <= rt_valid[k];
        fl_regs[k].tag   <= old_tags[k];
      end
    end
  end

  assign amt_o    = entries;
  assign amt_fl_o = fl_regs;

  // Retirement is still applied during rollback, but the ROB should never do it.
  always_ff @(posedge clk_i) begin
    if (rst_n_i) begin
      a_no_rt_on_rollback: assert (!(rollback_i && (|rt_valid)));
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_amt.sv
// Directed and model-checked stimulus for the architectural map table.
`default_nettype none

module tb_amt;
  import amt_pkg::*;

  logic                           clk_i;
  logic                           rst_n_i;
  logic                           rollback_i;
  rob_amt_t   [RT_NUM-1:0]        rob_amt_i;
  amt_entry_t [MT_ENTRY_NUM-1:0]  amt_o;
  amt_fl_t    [RT_NUM-1:0]        amt_fl_o;

  int compared   = 0;
  int mismatched = 0;

  amt dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .rollback_i (rollback_i),
    .rob_amt_i  (rob_amt_i),
    .amt_o      (amt_o),
    .amt_fl_o   (amt_fl_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input int observed, input int expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_ch(input int k, input bit v, input int a, input int t);
    rob_amt_i[k].valid    = v;
    rob_amt_i[k].arch_reg = ARCH_IDX_WIDTH'(a);
    rob_amt_i[k].tag      = TAG_IDX_WIDTH'(t);
  endtask

  task automatic clear_in();
    rob_amt_i = '0;
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    clear_in();
    rollback_i = 1'b0;
    repeat (2) step();
    rst_n_i = 1'b1;
    step();
  endtask

  int mdl [MT_ENTRY_NUM];
  int cnt [64];
  int pool[$];
  int exp_v[RT_NUM];
  int exp_t[RT_NUM];
  int bad;
  int a;
  int t;

  initial begin
    rst_n_i    = 1'b0;
    rollback_i = 1'b0;
    rob_amt_i  = '0;
    do_reset();

    // Reset state
    bad = 0;
    for (int i = 0; i < MT_ENTRY_NUM; i++) if (int'(amt_o[i].amt_tag) != i) bad++;
    chk("reset_identity_bad_entries", bad, 0);
    chk("reset_fl0", int'(amt_fl_o[0]), 0);
    chk("reset_fl1", int'(amt_fl_o[1]), 0);

    // Single retire x5 <- 40
    set_ch(0, 1'b1, 5, 40);
    step();
    clear_in();
    chk("single_amt5", int'(amt_o[5].amt_tag), 40);
    chk("single_fl0_valid", int'(amt_fl_o[0].valid), 1);
    chk("single_fl0_tag", int'(amt_fl_o[0].tag), 5);
    chk("single_fl1_valid", int'(amt_fl_o[1].valid), 0);
    step();
    chk("idle_fl0_valid", int'(amt_fl_o[0].valid), 0);
    chk("idle_amt5_held", int'(amt_o[5].amt_tag), 40);

    // Same-reg dual retire x7 <- 40 then 41
    set_ch(0, 1'b1, 7, 40);
    set_ch(1, 1'b1, 7, 41);
    step();
    clear_in();
    chk("dual_amt7", int'(amt_o[7].amt_tag), 41);
    chk("dual_fl0", int'(amt_fl_o[0]), int'({1'b1, 6'd7}));
    chk("dual_fl1", int'(amt_fl_o[1]), int'({1'b1, 6'd40}));

    // x0 retire
    set_ch(0, 1'b1, 0, 33);
    step();
    clear_in();
    chk("x0_amt0", int'(amt_o[0].amt_tag), 0);
    chk("x0_fl0", int'(amt_fl_o[0]), int'({1'b1, 6'd33}));

    // Gap channels: only ch1 valid
    set_ch(1, 1'b1, 3, 50);
    step();
    clear_in();
    chk("gap_amt3", int'(amt_o[3].amt_tag), 50);
    chk("gap_fl0_valid", int'(amt_fl_o[0].valid), 0);
    chk("gap_fl1", int'(amt_fl_o[1]), int'({1'b1, 6'd3}));

    // Rollback sequence: branch commit visible in the rollback cycle
    set_ch(0, 1'b1, 9, 44);
    step();
    clear_in();
    rollback_i = 1'b1;
    chk("rb_amt9_at_n1", int'(amt_o[9].amt_tag), 44);
    chk("rb_fl0", int'(amt_fl_o[0]), int'({1'b1, 6'd9}));
    step();
    rollback_i = 1'b0;
    chk("rb_amt9_held", int'(amt_o[9].amt_tag), 44);
    chk("rb_fl0_after", int'(amt_fl_o[0].valid), 0);

    // Reset mid-operation discards pending free-list output
    set_ch(0, 1'b1, 12, 55);
    set_ch(1, 1'b1, 13, 56);
    step();
    clear_in();
    chk("pre_rst_amt12", int'(amt_o[12].amt_tag), 55);
    #2 rst_n_i = 1'b0;
    #1;
    chk("async_rst_amt12", int'(amt_o[12].amt_tag), 12);
    chk("async_rst_amt9", int'(amt_o[9].amt_tag), 9);
    chk("async_rst_fl0", int'(amt_fl_o[0].valid), 0);
    chk("async_rst_fl1", int'(amt_fl_o[1].valid), 0);
    step();
    rst_n_i = 1'b1;
    step();

    // Random stream against a sequential golden model
    for (int i = 0; i < MT_ENTRY_NUM; i++) mdl[i] = i;
    for (int i = 0; i < 64; i++) cnt[i] = (i >= MT_ENTRY_NUM) ? 1 : 0;
    pool.delete();
    for (int i = MT_ENTRY_NUM; i < 64; i++) pool.push_back(i);
    for (int cyc = 0; cyc < 300; cyc++) begin
      clear_in();
      for (int k = 0; k < RT_NUM; k++) begin
        exp_v[k] = 0;
        exp_t[k] = 0;
        if (($urandom % 4) != 0) begin
          a = ($urandom % 8 == 0) ? 0 : int'($urandom_range(31, 1));
          if (cyc % 5 == 0) a = 17;
          t = pool.pop_front();
          cnt[t]--;
          set_ch(k, 1'b1, a, t);
          exp_v[k] = 1;
          if (a == 0) exp_t[k] = t;
          else begin
            exp_t[k] = mdl[a];
            mdl[a]   = t;
          end
        end
      end
      for (int k = 0; k < RT_NUM; k++) if (exp_v[k] != 0) pool.push_back(exp_t[k]);
      step();
      clear_in();
      for (int k = 0; k < RT_NUM; k++) begin
        chk($sformatf("rnd%0d_fl%0d", cyc, k), int'(amt_fl_o[k]),
            int'({exp_v[k][0], exp_t[k][5:0]}));
        if (amt_fl_o[k].valid) cnt[amt_fl_o[k].tag]++;
      end
      bad = 0;
      for (int i = 0; i < MT_ENTRY_NUM; i++) if (int'(amt_o[i].amt_tag) != mdl[i]) bad++;
      chk($sformatf("rnd%0d_map_bad", cyc), bad, 0);
    end

    // Final mapping plus freed tags must be a permutation of all tags
    for (int i = 0; i < MT_ENTRY_NUM; i++) cnt[amt_o[i].amt_tag]++;
    bad = 0;
    for (int i = 0; i < 64; i++) if (cnt[i] != 1) bad++;
    chk("perm_bad_tags", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
